// File: rtl/fpu_ex_stage.sv
// fpu_ex_stage: multi-cycle FADD/FSUB/FMUL execute unit (IEEE-754 single).
// Define FPU_ROUND_RNE_EN for round-to-nearest-even in PACK; default truncates.
module fpu_ex_stage #(
    parameter int MAX_NORM_SHIFT      = 26,
    parameter bit RESULT_ON_IDLE_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXvalid,
    output logic        EXready,
    input  logic [4:0]  EXFALUop,
    input  logic [4:0]  EXfRd,
    input  logic        EXfregWrite,
    input  logic [7:0]  EXexpDiff,
    input  logic        EXsign,
    input  logic        EXhidemax,
    input  logic        EXhidemin,
    input  logic [31:0] EXFloatMAX,
    input  logic [31:0] EXFloatMIN,
    output logic        WBvalid,
    output logic        WBfregWrite,
    output logic [4:0]  WBfRd,
    output logic [31:0] WBresult
);
    typedef enum logic [2:0] {IDLE, ALIGN, CALC, NORM, PACK} state_t;
    localparam int CW = $clog2(MAX_NORM_SHIFT + 1);

    state_t             state;
    logic [31:0]        fmax, fmin;
    logic [7:0]         ediff;
    logic               is_mul, msign, hmax, hmin;
    logic [4:0]         frd;
    logic               fregw;
    logic [26:0]        ma, mb, m;
    logic signed [9:0]  e;
    logic               sgn;
    logic [CW-1:0]      cnt;

    logic [26:0]        mmin0, align_b;
    logic [53:0]        sh;
    logic [47:0]        prod;
    logic [27:0]        sum;
    logic [26:0]        calc_m;
    logic signed [9:0]  calc_e;
    logic               calc_s;
    logic               norm_shift, norm_done, rnd_up;
    logic [26:0]        norm_m;
    logic signed [9:0]  norm_e, er;
    logic [CW-1:0]      norm_cnt;
    logic [24:0]        mr;
    logic [31:0]        norm_res, pack_val;
    logic               to_pack, wb_we;
    logic [4:0]         wb_rd;

    always_comb begin
        mmin0 = {hmin, fmin[22:0], 3'b000};
        sh    = {mmin0, 27'b0} >> ediff;
        if (ediff >= 8'd27) align_b = {26'b0, |mmin0};
        else                align_b = {sh[53:28], sh[27] | (|sh[26:0])};
    end

    always_comb begin
        prod   = {24'b0, hmax, fmax[22:0]} * {24'b0, hmin, fmin[22:0]};
        calc_e = $signed({2'b00, fmax[30:23]});
        calc_s = fmax[31];
        if (is_mul) begin
            calc_e = calc_e + $signed({2'b00, fmin[30:23]}) - 10'sd127;
            calc_s = msign;
            sum    = {prod[47:21], |prod[20:0]};
        end else if (fmax[31] ^ fmin[31]) begin
            sum = {1'b0, ma} - {1'b0, mb};
        end else begin
            sum = {1'b0, ma} + {1'b0, mb};
        end
        // carry out: renormalize right, folding the lost bit into sticky
        if (sum[27]) begin
            calc_m = {sum[27:2], sum[1] | sum[0]};
            calc_e = calc_e + 10'sd1;
        end else begin
            calc_m = sum[26:0];
        end
    end

    always_comb begin
        norm_shift = !m[26] && (e > 10'sd1) && (cnt < CW'(MAX_NORM_SHIFT));
        norm_m     = norm_shift ? {m[25:0], 1'b0} : m;
        norm_e     = norm_shift ? e - 10'sd1 : e;
        norm_cnt   = norm_shift ? cnt + CW'(1) : cnt;
        norm_done  = !norm_shift || norm_m[26] || (norm_e <= 10'sd1) ||
                     (norm_cnt >= CW'(MAX_NORM_SHIFT));
    end

`ifdef FPU_ROUND_RNE_EN
    assign rnd_up = norm_m[2] & (norm_m[1] | norm_m[0] | norm_m[3]);
`else
    assign rnd_up = 1'b0;
`endif

    always_comb begin
        mr = {1'b0, norm_m[26:3]} + {24'b0, rnd_up};
        er = norm_e;
        if (mr[24]) begin
            mr = mr >> 1;
            er = er + 10'sd1;
        end
        if (norm_e <= 10'sd0 || (norm_e == 10'sd1 && !norm_m[26]))
            norm_res = {sgn, 31'b0};
        else if (er >= 10'sd255)
            norm_res = {sgn, 8'hFF, 23'b0};
        else
            norm_res = {sgn, er[7:0], mr[22:0]};
    end

    always_comb begin
        to_pack  = 1'b0;
        pack_val = '0;
        wb_rd    = frd;
        wb_we    = fregw;
        unique case (state)
            IDLE: begin
                to_pack  = EXvalid && EXready && (EXFALUop > 5'd2);
                pack_val = EXFloatMAX;
                wb_rd    = EXfRd;
                wb_we    = EXfregWrite;
            end
            CALC: begin
                to_pack  = (fmax[30:23] == 8'hFF);
                pack_val = fmax;
            end
            NORM: begin
                to_pack  = (m == '0) || norm_done;
                pack_val = (m == '0) ? 32'b0 : norm_res;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            EXready     <= 1'b1;
            WBvalid     <= 1'b0;
            WBfregWrite <= 1'b0;
            WBfRd       <= '0;
            WBresult    <= '0;
            fmax        <= '0;
            fmin        <= '0;
            ediff       <= '0;
            is_mul      <= 1'b0;
            msign       <= 1'b0;
            hmax        <= 1'b0;
            hmin        <= 1'b0;
            frd         <= '0;
            fregw       <= 1'b0;
            ma          <= '0;
            mb          <= '0;
            m           <= '0;
            e           <= '0;
            sgn         <= 1'b0;
            cnt         <= '0;
        end else begin
            unique case (state)
                IDLE: if (EXvalid && EXready) begin
                    fmax    <= EXFloatMAX;
                    fmin    <= EXFloatMIN;
                    ediff   <= EXexpDiff;
                    is_mul  <= (EXFALUop == 5'd2);
                    msign   <= EXsign;
                    hmax    <= EXhidemax;
                    hmin    <= EXhidemin;
                    frd     <= EXfRd;
                    fregw   <= EXfregWrite;
                    EXready <= 1'b0;
                    state   <= (EXFALUop <= 5'd2) ? ALIGN : PACK;
                end
                ALIGN: begin
                    ma    <= {hmax, fmax[22:0], 3'b000};
                    mb    <= align_b;
                    state <= CALC;
                end
                CALC: begin
                    m     <= calc_m;
                    e     <= calc_e;
                    sgn   <= calc_s;
                    cnt   <= '0;
                    state <= to_pack ? PACK : NORM;
                end
                NORM: begin
                    m   <= norm_m;
                    e   <= norm_e;
                    cnt <= norm_cnt;
                    if (to_pack) state <= PACK;
                end
                PACK: begin
                    state       <= IDLE;
                    EXready     <= 1'b1;
                    WBvalid     <= 1'b0;
                    WBfregWrite <= 1'b0;
                    if (RESULT_ON_IDLE_ZERO) WBresult <= '0;
                end
                default: state <= IDLE;
            endcase
            if (to_pack) begin
                WBvalid     <= 1'b1;
                WBresult    <= pack_val;
                WBfRd       <= wb_rd;
                WBfregWrite <= wb_we;
            end
        end
    end
endmodule

// File: doc/fpu_ex_stage.md
Name: fpu_ex_stage

Overview:
- Multi-cycle floating-point execute unit. It consumes the registered PRE-to-EX pipeline outputs: larger/smaller operand, exponent difference, hidden bits and sign.
- Performs FADD/FSUB/FMUL on IEEE-754 single precision and delivers the result to the write-back stage with a valid pulse.
- Holds the FPU pipeline busy via EXready while iterating.

Parameters:
- MAX_NORM_SHIFT, 26, upper bound on NORM iterations (guard against lockup).
- RESULT_ON_IDLE_ZERO, 1, 1 = clear WBresult to 0 whenever WBvalid is low.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- EXvalid  in  1  operand bundle present this cycle
- EXready  out  1  1 only in IDLE; a bundle is accepted when EXvalid & EXready
- EXFALUop  in  5  0=FADD, 1=FSUB, 2=FMUL, other=pass EXFloatMAX
- EXfRd  in  5  destination float register
- EXfregWrite  in  1  write-enable carried to WB
- EXexpDiff  in  8  exponent(MAX) minus exponent(MIN)
- EXsign  in  1  product sign (FMUL only)
- EXhidemax  in  1  hidden bit of MAX
- EXhidemin  in  1  hidden bit of MIN
- EXFloatMAX  in  32  larger-magnitude operand
- EXFloatMIN  in  32  smaller-magnitude operand
- WBvalid  out  1  one-cycle result pulse
- WBfregWrite  out  1  latched EXfregWrite, qualified by WBvalid
- WBfRd  out  5  latched EXfRd
- WBresult  out  32  packed result

Behaviour:
- Reset values: state IDLE, EXready=1, WBvalid=0, WBfregWrite=0, WBfRd=0, WBresult=0, all internal registers 0.
- Reset mid-operation aborts the operation; no WBvalid pulse is produced for it.
- Operand convention: FSUB negation is already folded into the operand sign bits upstream, so FADD and FSUB execute identically.
- States: IDLE, ALIGN, CALC, NORM, PACK.
- IDLE: on acceptance, latch all EX* inputs.
  - Op 0/1/2 go to ALIGN.
  - Any other op goes to PACK with result = EXFloatMAX.
  - EXvalid while not in IDLE is ignored; the upstream stage must stall on EXready=0.
- ALIGN (1 cycle):
  - Form 27-bit mantissas {hide, frac[22:0], 3'b000}.
  - Shift the MIN mantissa right by expDiff, OR-ing shifted-out bits into bit 0 (sticky).
  - expDiff >= 27: MIN mantissa becomes {26'b0, |original}.
  - FMUL: ALIGN is a pass-through cycle.
- CALC (1 cycle):
  - Add/sub: eff_sub = MAX[31]^MIN[31]; 28-bit sum = eff_sub ? max-min : max+min; e = MAX[30:23]; sign = MAX[31].
  - Add/sub carry (bit27 set): shift right 1 keeping sticky; e += 1.
  - FMUL: product = 24x24 -> 48 bits, truncated to a 27-bit window plus sticky; e = eMAX + eMIN - 127 in a signed 10-bit value; sign = EXsign. Bit47 set: shift right 1, e += 1.
- NORM:
  - Zero mantissa: result +0, go to PACK.
  - Otherwise, while bit26 = 0 and e > 1 and shifts < MAX_NORM_SHIFT: shift left 1 and e -= 1, one bit per cycle.
  - Exit to PACK when bit26 = 1 or a limit is reached. At least 1 NORM cycle always occurs.
- PACK (1 cycle):
  - Default rounding is truncation: the 3 low bits are discarded.
  - e >= 255: result {sign, 8'hFF, 23'b0}.
  - e <= 0, or bit26 = 0 at e = 1: result {sign, 31'b0}, i.e. denormals are flushed to zero.
  - Otherwise {sign, e[7:0], m[25:3]}.
  - WBvalid=1 this cycle; return to IDLE, so EXready=1 on the next cycle.
- MAX exponent 8'hFF on input: result = EXFloatMAX (inf/NaN pass-through), taken from CALC straight to PACK.
- Latency: acceptance edge at T; ALIGN at T+1, CALC at T+2, NORM T+3..T+2+k, PACK (WBvalid) at T+3+k, where k >= 1. Pass-through ops: WBvalid at T+1.
- WBfRd/WBfregWrite hold their latched values until the next PACK.

Optional Feature:
- FPU_ROUND_RNE_EN defined: PACK rounds to nearest, ties to even, using bits[2:0] as guard/round/sticky.
  - Mantissa overflow on increment re-normalizes, with e += 1.
  - e reaching 255 produces inf.
  - Same cycle count as truncation.
- Undefined: truncation as above.

Test Plan:
- FADD 0x3F800000 + 0x3F800000, expDiff 0 -> carry in CALC; WBresult 0x40000000, WBvalid at T+4.
- FADD MAX 0x3FC00000, MIN 0xBFC00000, expDiff 0 -> zero sum; WBresult 0x00000000 at T+4.
- FSUB MAX 0x3F800000, MIN 0xBF7FFFFF, expDiff 1 -> 24 NORM shifts; WBresult 0x33800000, WBvalid at T+27; EXready=0 throughout.
- FMUL MAX 0x40400000, MIN 0x40000000, EXsign 0 -> WBresult 0x40C00000; second EXvalid pulse during the busy window is ignored; exactly one WBvalid.
- FADD MAX 0x3F800000, MIN 0x30800000, expDiff 30 -> sticky only; WBresult 0x3F800000 under both truncation and RNE.
- rst asserted mid-NORM of the 0x3F800000/0xBF7FFFFF case -> outputs 0 immediately, EXready=1, no WBvalid; next FADD completes correctly.
